// File: rtl/abp_frame_receiver.sv
// rtl/abp_frame_receiver.sv - alternating-bit / sequence-number frame receiver
//
// Purpose : Collects a byte stream into frames of the form header, value
//           (little-endian, VALUE_BYTES long), trailing bytes. A frame whose
//           sequence matches expected_seq is delivered on value_o and
//           acknowledged. A repeated frame is acknowledged but not delivered.
//           Short and over-long frames are dropped with err_len and get no ack.
// Ports   : aclk, aresetn                 clock, async active-low reset
//           s_axis_tdata/tvalid/tready/tlast   incoming byte stream
//           value_o, value_valid           delivered value and strobe
//           ack_valid/ack_ready/ack_seq    acknowledgement handshake
//           busy, expected_seq             status
//           err_len, err_dup, dup_count    error strobes, duplicate counter
// Macro   : ABP_RX_CHECKSUM_EN - the last byte of each frame must equal the XOR
//           of all preceding bytes; the minimum frame length grows by one.
module abp_frame_receiver #(
    parameter int VALUE_BYTES     = 8,
    parameter int MAX_FRAME_BYTES = 64,
    parameter int SEQ_BITS        = 1
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic [7:0]               s_axis_tdata,
    output logic [8*VALUE_BYTES-1:0] value_o,
    output logic                     value_valid,
    output logic                     ack_valid,
    input  logic                     ack_ready,
    output logic [SEQ_BITS-1:0]      ack_seq,
    output logic                     busy,
    output logic [SEQ_BITS-1:0]      expected_seq,
    output logic                     err_len,
    output logic                     err_dup,
    output logic [15:0]              dup_count
);

    localparam int CNT_W = 9;
    localparam int VW    = 8 * VALUE_BYTES;
`ifdef ABP_RX_CHECKSUM_EN
    localparam int MIN_LEN = VALUE_BYTES + 2;
`else
    localparam int MIN_LEN = VALUE_BYTES + 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_DRAIN,
        S_CHECK,
        S_ACK
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEQ_BITS-1:0] rx_seq_q, rx_seq_d;
    logic [VW-1:0]       shadow_q, shadow_d;
    logic [VW-1:0]       value_q, value_d;
    logic                value_valid_q, value_valid_d;
    logic [SEQ_BITS-1:0] ack_seq_q, ack_seq_d;
    logic [SEQ_BITS-1:0] exp_q, exp_d;
    logic                err_len_q, err_len_d;
    logic                err_dup_q, err_dup_d;
    logic [15:0]         dup_q, dup_d;
    logic                rdy_en_q, rdy_en_d;
`ifdef ABP_RX_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif
    logic                beat;

    // rdy_en_q holds tready low until the first edge after reset release,
    // even though the state register already sits in IDLE during reset.
    assign s_axis_tready = rdy_en_q &&
                           (state_q == S_IDLE || state_q == S_RECV || state_q == S_DRAIN);
    assign beat          = s_axis_tvalid && s_axis_tready;

    assign value_o      = value_q;
    assign value_valid  = value_valid_q;
    assign ack_valid    = (state_q == S_ACK);
    assign ack_seq      = ack_seq_q;
    assign busy         = (state_q != S_IDLE);
    assign expected_seq = exp_q;
    assign err_len      = err_len_q;
    assign err_dup      = err_dup_q;
    assign dup_count    = dup_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rx_seq_d      = rx_seq_q;
        shadow_d      = shadow_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        ack_seq_d     = ack_seq_q;
        exp_d         = exp_q;
        err_len_d     = 1'b0;
        err_dup_d     = 1'b0;
        dup_d         = dup_q;
        rdy_en_d      = 1'b1;
`ifdef ABP_RX_CHECKSUM_EN
        csum_d        = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    rx_seq_d = s_axis_tdata[SEQ_BITS-1:0];
                    cnt_d    = CNT_W'(1);
`ifdef ABP_RX_CHECKSUM_EN
                    csum_d   = s_axis_tdata;
`endif
                    state_d  = s_axis_tlast ? S_CHECK : S_RECV;
                end
            end
            S_RECV: begin
                if (beat) begin
                    // cnt_q is the index of the byte now arriving; index k
                    // (1..VALUE_BYTES) is value byte k-1.
                    for (int i = 0; i < VALUE_BYTES; i++) begin
                        if (cnt_q == CNT_W'(i + 1)) begin
                            shadow_d[i*8 +: 8] = s_axis_tdata;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef ABP_RX_CHECKSUM_EN
                    csum_d = csum_q ^ s_axis_tdata;
`endif
                    if (s_axis_tlast) begin
                        state_d = S_CHECK;
                    end else if (cnt_q + CNT_W'(1) == CNT_W'(MAX_FRAME_BYTES)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (beat && s_axis_tlast) begin
                    err_len_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_CHECK: begin
                if (cnt_q < CNT_W'(MIN_LEN)) begin
                    err_len_d = 1'b1;
                    state_d   = S_IDLE;
`ifdef ABP_RX_CHECKSUM_EN
                end else if (csum_q != 8'h00) begin
                    // XOR over all bytes including the checksum is zero when intact
                    err_len_d = 1'b1;
                    state_d   = S_IDLE;
`endif
                end else if (rx_seq_q == exp_q) begin
                    value_d       = shadow_q;
                    value_valid_d = 1'b1;
                    exp_d         = exp_q + SEQ_BITS'(1);
                    ack_seq_d     = rx_seq_q;
                    state_d       = S_ACK;
                end else begin
                    err_dup_d = 1'b1;
                    if (dup_q != 16'hFFFF) begin
                        dup_d = dup_q + 16'd1;
                    end
                    ack_seq_d = rx_seq_q;
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                if (ack_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rx_seq_q      <= '0;
            shadow_q      <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            ack_seq_q     <= '0;
            exp_q         <= '0;
            err_len_q     <= 1'b0;
            err_dup_q     <= 1'b0;
            dup_q         <= '0;
            rdy_en_q      <= 1'b0;
`ifdef ABP_RX_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rx_seq_q      <= rx_seq_d;
            shadow_q      <= shadow_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            ack_seq_q     <= ack_seq_d;
            exp_q         <= exp_d;
            err_len_q     <= err_len_d;
            err_dup_q     <= err_dup_d;
            dup_q         <= dup_d;
            rdy_en_q      <= rdy_en_d;
`ifdef ABP_RX_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_abp_frame_receiver.sv
// tb/tb_abp_frame_receiver.sv - directed self-checking bench for abp_frame_receiver
module tb_abp_frame_receiver;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic [7:0]  tdata = 8'h00;
    logic        ack_ready = 1'b0;
    logic        sel = 1'b0;

    logic        tready0, vv0, ack_valid0, busy0, err_len0, err_dup0;
    logic [63:0] value0;
    logic [0:0]  ack_seq0, exp0;
    logic [15:0] dup0;

    logic        tready1, vv1, ack_valid1, busy1, err_len1, err_dup1;
    logic [63:0] value1;
    logic [1:0]  ack_seq1, exp1;
    logic [15:0] dup1;

    logic        tvalid0, tvalid1, ack_ready0, ack_ready1, tready_m;

    assign tvalid0    = tvalid & ~sel;
    assign tvalid1    = tvalid & sel;
    assign ack_ready0 = ack_ready & ~sel;
    assign ack_ready1 = ack_ready & sel;
    assign tready_m   = sel ? tready1 : tready0;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  fb [0:79];
    int          flen = 0;
    int          wait0 = 0;

    always #5 aclk = ~aclk;

    abp_frame_receiver u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(tvalid0), .s_axis_tready(tready0),
        .s_axis_tlast(tlast), .s_axis_tdata(tdata),
        .value_o(value0), .value_valid(vv0),
        .ack_valid(ack_valid0), .ack_ready(ack_ready0), .ack_seq(ack_seq0),
        .busy(busy0), .expected_seq(exp0),
        .err_len(err_len0), .err_dup(err_dup0), .dup_count(dup0)
    );

    abp_frame_receiver #(.SEQ_BITS(2)) u_dut2 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(tvalid1), .s_axis_tready(tready1),
        .s_axis_tlast(tlast), .s_axis_tdata(tdata),
        .value_o(value1), .value_valid(vv1),
        .ack_valid(ack_valid1), .ack_ready(ack_ready1), .ack_seq(ack_seq1),
        .busy(busy1), .expected_seq(exp1),
        .err_len(err_len1), .err_dup(err_dup1), .dup_count(dup1)
    );

    // header, value bytes base, base+1, ..., XOR of all preceding bytes last
    task automatic build(input logic [7:0] hdr, input logic [7:0] base, input int len);
        logic [7:0] x;
        fb[0] = hdr;
        x = hdr;
        for (int i = 1; i < len - 1; i++) begin
            fb[i] = base + 8'(i - 1);
            x = x ^ fb[i];
        end
        fb[len-1] = x;
        flen = len;
    endtask

    // Sends fb[0..n-1]; called and returns at a falling edge.
    task automatic send_frame(input int n, input bit with_last);
        int w;
        bit acc;
        for (int b = 0; b < n; b++) begin
            tvalid = 1'b1;
            tdata  = fb[b];
            tlast  = with_last && (b == n - 1);
            acc = 1'b0;
            w = 0;
            while (!acc && w < 40) begin
                acc = tready_m;
                @(posedge aclk);
                @(negedge aclk);
                if (!acc) w++;
            end
            if (b == 0) wait0 = w;
            if (!acc) begin
                checks++;
                failures++;
                $display("FAIL byte_accept byte=%0d waited=%0d required=accepted", b, w);
                break;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        checks++;
        if ({tready0, vv0, ack_valid0, busy0, err_len0, err_dup0} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {tready0, vv0, ack_valid0, busy0, err_len0, err_dup0});
        end
        checks++;
        if ({value0, ack_seq0, exp0, dup0} !== 82'd0) begin
            failures++;
            $display("FAIL reset_values value=%h ack_seq=%0d exp=%0d dup=%0d exp=all0",
                     value0, ack_seq0, exp0, dup0);
        end
        aresetn = 1'b1;
        #1;
        checks++;
        if (tready0 !== 1'b0) begin
            failures++;
            $display("FAIL tready_before_edge got=%b exp=0", tready0);
        end
        @(negedge aclk);
        checks++;
        if (tready0 !== 1'b1) begin
            failures++;
            $display("FAIL tready_after_edge got=%b exp=1", tready0);
        end
    endtask

    task automatic test_deliver();
        build(8'h00, 8'h01, 10);
        send_frame(flen, 1'b1);
        checks++;
        if ({vv0, busy0, tready0} !== 3'b010) begin
            failures++;
            $display("FAIL check_cycle vv/busy/tready got=%b exp=010", {vv0, busy0, tready0});
        end
        @(negedge aclk);
        checks++;
        if ({vv0, ack_valid0, ack_seq0, exp0} !== 4'b1101) begin
            failures++;
            $display("FAIL deliver vv/ack/ack_seq/exp got=%b exp=1101",
                     {vv0, ack_valid0, ack_seq0, exp0});
        end
        checks++;
        if (value0 !== 64'h0807060504030201) begin
            failures++;
            $display("FAIL deliver_value got=%h exp=0807060504030201", value0);
        end
        ack_ready = 1'b1;
        @(negedge aclk);
        ack_ready = 1'b0;
        checks++;
        if ({ack_valid0, busy0, vv0} !== 3'b000) begin
            failures++;
            $display("FAIL deliver_idle ack/busy/vv got=%b exp=000", {ack_valid0, busy0, vv0});
        end
    endtask

    task automatic test_dup();
        build(8'h00, 8'h01, 10);
        send_frame(flen, 1'b1);
        @(negedge aclk);
        checks++;
        if ({vv0, err_dup0, ack_valid0, ack_seq0, exp0} !== 5'b01101) begin
            failures++;
            $display("FAIL dup vv/err_dup/ack/ack_seq/exp got=%b exp=01101",
                     {vv0, err_dup0, ack_valid0, ack_seq0, exp0});
        end
        checks++;
        if (dup0 !== 16'd1 || value0 !== 64'h0807060504030201) begin
            failures++;
            $display("FAIL dup_count/value got=%0d/%h exp=1/0807060504030201", dup0, value0);
        end
        ack_ready = 1'b1;
        @(negedge aclk);
        ack_ready = 1'b0;
    endtask

    task automatic test_ack_hold();
        build(8'h01, 8'h11, 10);
        send_frame(flen, 1'b1);
        @(negedge aclk);
        checks++;
        if ({vv0, exp0} !== 2'b10 || value0 !== 64'h1817161514131211) begin
            failures++;
            $display("FAIL hold_deliver vv=%b exp=%0d value=%h required vv=1 exp=0 value=1817161514131211",
                     vv0, exp0, value0);
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({ack_valid0, ack_seq0, tready0} !== 3'b110) begin
                failures++;
                $display("FAIL ack_hold cycle=%0d ack/seq/tready got=%b exp=110",
                         c, {ack_valid0, ack_seq0, tready0});
            end
            @(negedge aclk);
        end
        ack_ready = 1'b1;
        @(negedge aclk);
        ack_ready = 1'b0;
        checks++;
        if ({ack_valid0, busy0, tready0} !== 3'b001) begin
            failures++;
            $display("FAIL ack_release ack/busy/tready got=%b exp=001", {ack_valid0, busy0, tready0});
        end
    endtask

    task automatic test_back_to_back();
        build(8'h00, 8'hA1, 10);
        send_frame(flen, 1'b1);
        checks++;
        if (wait0 !== 0) begin
            failures++;
            $display("FAIL b2b_first_byte_wait got=%0d exp=0", wait0);
        end
        @(negedge aclk);
        checks++;
        if (vv0 !== 1'b1 || value0 !== 64'hA8A7A6A5A4A3A2A1 || exp0 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_deliver vv=%b value=%h exp=%0d required 1/A8A7A6A5A4A3A2A1/1",
                     vv0, value0, exp0);
        end
        ack_ready = 1'b1;
        @(negedge aclk);
        ack_ready = 1'b0;
    endtask

    task automatic test_short();
        build(8'h01, 8'h21, 3);
        send_frame(flen, 1'b1);
        @(negedge aclk);
        checks++;
        if ({err_len0, ack_valid0, vv0, busy0, exp0} !== 5'b10001) begin
            failures++;
            $display("FAIL short3 err_len/ack/vv/busy/exp got=%b exp=10001",
                     {err_len0, ack_valid0, vv0, busy0, exp0});
        end
        @(negedge aclk);
        checks++;
        if ({err_len0, ack_valid0} !== 2'b00) begin
            failures++;
            $display("FAIL short3_after err_len/ack got=%b exp=00", {err_len0, ack_valid0});
        end
        build(8'h01, 8'h00, 1);
        send_frame(flen, 1'b1);
        @(negedge aclk);
        checks++;
        if ({err_len0, ack_valid0, vv0, busy0} !== 4'b1000 || dup0 !== 16'd1) begin
            failures++;
            $display("FAIL short1 err_len/ack/vv/busy=%b dup=%0d required 1000/1",
                     {err_len0, ack_valid0, vv0, busy0}, dup0);
        end
    endtask

    task automatic test_max_len();
        build(8'h01, 8'h31, 64);
        send_frame(flen, 1'b1);
        @(negedge aclk);
        checks++;
        if ({vv0, ack_valid0, ack_seq0, exp0, err_len0} !== 5'b11100 ||
            value0 !== 64'h3837363534333231) begin
            failures++;
            $display("FAIL max64 vv/ack/seq/exp/err_len=%b value=%h required 11100/3837363534333231",
                     {vv0, ack_valid0, ack_seq0, exp0, err_len0}, value0);
        end
        ack_ready = 1'b1;
        @(negedge aclk);
        ack_ready = 1'b0;
    endtask

    task automatic test_drain();
        build(8'h00, 8'h41, 70);
        send_frame(flen, 1'b1);
        checks++;
        if ({err_len0, ack_valid0, busy0, vv0} !== 4'b1000) begin
            failures++;
            $display("FAIL drain err_len/ack/busy/vv got=%b exp=1000",
                     {err_len0, ack_valid0, busy0, vv0});
        end
        @(negedge aclk);
        checks++;
        if ({err_len0, ack_valid0, exp0} !== 3'b000 || dup0 !== 16'd1) begin
            failures++;
            $display("FAIL drain_after err_len/ack/exp=%b dup=%0d required 000/1",
                     {err_len0, ack_valid0, exp0}, dup0);
        end
    endtask

    task automatic test_reset_mid();
        build(8'h00, 8'h51, 10);
        send_frame(4, 1'b0);
        aresetn = 1'b0;
        #1;
        checks++;
        if ({tready0, busy0, ack_valid0, vv0} !== 4'b0000 ||
            {value0, exp0, dup0, ack_seq0} !== 82'd0) begin
            failures++;
            $display("FAIL reset_mid tready/busy/ack/vv=%b value=%h exp=%0d dup=%0d seq=%0d required all 0",
                     {tready0, busy0, ack_valid0, vv0}, value0, exp0, dup0, ack_seq0);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        build(8'h00, 8'h01, 10);
        send_frame(flen, 1'b1);
        @(negedge aclk);
        checks++;
        if ({vv0, ack_valid0, ack_seq0, exp0} !== 4'b1101 || value0 !== 64'h0807060504030201) begin
            failures++;
            $display("FAIL reset_mid_frame vv/ack/seq/exp=%b value=%h required 1101/0807060504030201",
                     {vv0, ack_valid0, ack_seq0, exp0}, value0);
        end
        ack_ready = 1'b1;
        @(negedge aclk);
        ack_ready = 1'b0;
    endtask

    task automatic test_seq2();
        logic [7:0]  hdrs [0:4];
        logic [7:0]  bases [0:4];
        logic [1:0]  exps [0:4];
        logic [63:0] ev;
        hdrs  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
        bases = '{8'h61, 8'h71, 8'h81, 8'h91, 8'hA1};
        exps  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        sel = 1'b1;
        @(negedge aclk);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 8; i++) ev[i*8 +: 8] = bases[k] + 8'(i);
            build(hdrs[k], bases[k], 10);
            send_frame(flen, 1'b1);
            @(negedge aclk);
            checks++;
            if (vv1 !== 1'b1 || value1 !== ev || exp1 !== exps[k] ||
                ack_valid1 !== 1'b1 || ack_seq1 !== hdrs[k][1:0]) begin
                failures++;
                $display("FAIL seq2 frame=%0d vv=%b value=%h exp=%0d ack=%b seq=%0d required 1/%h/%0d/1/%0d",
                         k, vv1, value1, exp1, ack_valid1, ack_seq1, ev, exps[k], hdrs[k][1:0]);
            end
            ack_ready = 1'b1;
            @(negedge aclk);
            ack_ready = 1'b0;
        end
`ifdef ABP_RX_CHECKSUM_EN
        build(8'h01, 8'hB1, 10);
        fb[9] = fb[9] ^ 8'hFF;
        send_frame(flen, 1'b1);
        @(negedge aclk);
        checks++;
        if ({err_len1, ack_valid1, vv1} !== 3'b100 || exp1 !== 2'd1) begin
            failures++;
            $display("FAIL checksum_bad err_len/ack/vv=%b exp=%0d required 100/1",
                     {err_len1, ack_valid1, vv1}, exp1);
        end
`endif
        sel = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge aclk);
        test_reset();
        test_deliver();
        test_dup();
        test_ack_hold();
        test_back_to_back();
        test_short();
        test_max_len();
        test_drain();
        test_reset_mid();
        test_seq2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
